// File: rtl/bomb_pkg.sv
// Shared encodings for the bomb game: controller state values and wire-cut result codes.
// The display muxes import this package as well, so encodings change in one place only.
package bomb_pkg;

    typedef enum logic [1:0] {
        ST_HOME     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_DEFUSED  = 2'd2,
        ST_EXPLODED = 2'd3
    } bomb_state_t;

    localparam logic [2:0] CUT_DEFUSE = 3'b101;
    localparam logic [2:0] CUT_WRONG  = 3'b111;
    localparam int         ELAPSED_W  = 16;

    function automatic logic is_terminal(input bomb_state_t s);
        return (s == ST_DEFUSED) || (s == ST_EXPLODED);
    endfunction

endpackage

// File: rtl/flash_seq.sv
// Post-game blink sequencer: starts high, toggles every BLINK_MS ticks for FLASH_CYCLES
// half-periods, then settles on steady_level.
module flash_seq #(
    parameter int BLINK_MS     = 250,
    parameter int FLASH_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    input  logic steady_level,
    output logic flash
);

    localparam int TICK_W = $clog2(BLINK_MS + 1);
    localparam int HALF_W = $clog2(FLASH_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_MS - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(FLASH_CYCLES - 1);
    localparam logic [HALF_W-1:0] HALF_DONE = HALF_W'(FLASH_CYCLES);

    logic [TICK_W-1:0] tick_cnt;
    logic [HALF_W-1:0] half_cnt;
    logic              active;
    logic              running;

    assign running = active && (half_cnt != HALF_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            flash    <= 1'b0;
            tick_cnt <= '0;
            half_cnt <= '0;
            active   <= 1'b0;
        end else if (start) begin
            // A tick landing on the entry cycle already belongs to the first half-period.
            flash    <= 1'b1;
            tick_cnt <= TICK_W'(tick);
            half_cnt <= '0;
            active   <= 1'b1;
        end else if (running && tick) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                half_cnt <= half_cnt + HALF_W'(1);
                flash    <= (half_cnt == HALF_LAST) ? steady_level : ~flash;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/bomb_state_ctrl.sv
// Top-level game controller: HOME / ARMED / DEFUSED / EXPLODED sequencing, terminal strobes,
// saturating time-in-play counter and the end-of-game flash.
module bomb_state_ctrl
    import bomb_pkg::*;
#(
    parameter int BLINK_MS     = 250,
    parameter int FLASH_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 tick_1khz,
    input  logic [2:0]           wire_cut,
    input  logic                 times_up,
    output logic [1:0]           state,
    output logic                 game_reset,
    output logic                 defuse_pulse,
    output logic                 explode_pulse,
    output logic                 flash,
    output logic [ELAPSED_W-1:0] elapsed_ms
);

    function automatic logic [ELAPSED_W-1:0] sat_inc(input logic [ELAPSED_W-1:0] v);
        return (v == '1) ? v : v + ELAPSED_W'(1);
    endfunction

    logic        arm_p0, tick_p0, times_up_p0;
    logic [2:0]  cut_p0;
    bomb_state_t state_q, state_d;
    logic        def_entry, exp_entry;
    logic        seq_flash;

    // Stage p0: every input is registered once; all decisions below use these copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_p0      <= 1'b0;
            tick_p0     <= 1'b0;
            times_up_p0 <= 1'b0;
            cut_p0      <= '0;
        end else begin
            arm_p0      <= arm;
            tick_p0     <= tick_1khz;
            times_up_p0 <= times_up;
            cut_p0      <= wire_cut;
        end
    end

    // Stage p1: state register plus the terminal strobes that coincide with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_HOME;
            defuse_pulse  <= 1'b0;
            explode_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            defuse_pulse  <= def_entry;
            explode_pulse <= exp_entry;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!arm_p0) begin
            state_d = ST_HOME;
        end else begin
            unique case (state_q)
                ST_HOME:
                    if (cut_p0 != CUT_DEFUSE && cut_p0 != CUT_WRONG && !times_up_p0)
                        state_d = ST_ARMED;
                ST_ARMED:
                    if (cut_p0 == CUT_DEFUSE)
                        state_d = ST_DEFUSED;
                    else if (cut_p0 == CUT_WRONG || times_up_p0)
                        state_d = ST_EXPLODED;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        state      = state_q;
        game_reset = (state_q == ST_HOME);
        def_entry  = (state_d == ST_DEFUSED)  && (state_q != ST_DEFUSED);
        exp_entry  = (state_d == ST_EXPLODED) && (state_q != ST_EXPLODED);
        flash      = is_terminal(state_q) ? seq_flash : 1'b0;
    end

    // Counts only in ARMED; the entry cycle's tick belongs to ARMED, terminal states freeze it.
    always_ff @(posedge clk) begin
        if (reset) begin
            elapsed_ms <= '0;
        end else if (state_d == ST_ARMED) begin
            if (state_q != ST_ARMED)
                elapsed_ms <= ELAPSED_W'(tick_p0);
            else if (tick_p0)
                elapsed_ms <= sat_inc(elapsed_ms);
        end else if (state_d == ST_HOME) begin
            elapsed_ms <= '0;
        end
    end

    flash_seq #(
        .BLINK_MS    (BLINK_MS),
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_flash_seq (
        .clk         (clk),
        .reset       (reset),
        .start       (def_entry || exp_entry),
        .tick        (tick_p0),
        .steady_level(state_q == ST_DEFUSED),
        .flash       (seq_flash)
    );

endmodule

// File: tb/tb_bomb_state_ctrl.sv
// Scoreboard bench for bomb_state_ctrl: expectations are queued when stimulus is applied
// and popped in order as DUT outputs are sampled one time unit after the rising edge.
module tb_bomb_state_ctrl;
    import bomb_pkg::*;

    localparam int BLINK_MS     = 250;
    localparam int FLASH_CYCLES = 10;

    logic        clk = 1'b0;
    logic        reset, arm, tick_1khz, times_up;
    logic [2:0]  wire_cut;
    logic [1:0]  state;
    logic        game_reset, defuse_pulse, explode_pulse, flash;
    logic [15:0] elapsed_ms;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_def = 0;
    int   n_exp = 0;

    always #5 clk = ~clk;

    bomb_state_ctrl #(
        .BLINK_MS    (BLINK_MS),
        .FLASH_CYCLES(FLASH_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .tick_1khz    (tick_1khz),
        .wire_cut     (wire_cut),
        .times_up     (times_up),
        .state        (state),
        .game_reset   (game_reset),
        .defuse_pulse (defuse_pulse),
        .explode_pulse(explode_pulse),
        .flash        (flash),
        .elapsed_ms   (elapsed_ms)
    );

    always @(negedge clk) begin
        if (defuse_pulse === 1'b1) n_def++;
        if (explode_pulse === 1'b1) n_exp++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hp;

        // Reset with arm already high: HOME, then ARMED two edges after release.
        reset = 1'b1; arm = 1'b1; tick_1khz = 1'b0; wire_cut = 3'b000; times_up = 1'b0;
        push_exp("rst_state", ST_HOME);
        push_exp("rst_game_reset", 1);
        push_exp("rst_flash", 0);
        push_exp("rst_pulses", 0);
        push_exp("rst_elapsed", 0);
        step(1);
        observe(state); observe(game_reset); observe(flash);
        observe({defuse_pulse, explode_pulse}); observe(elapsed_ms);

        reset = 1'b0;
        push_exp("rel1_state", ST_HOME);
        step(1);
        observe(state);
        push_exp("arm_state", ST_ARMED);
        push_exp("arm_game_reset", 0);
        push_exp("arm_elapsed", 0);
        step(1);
        observe(state); observe(game_reset); observe(elapsed_ms);

        // Normal defuse after 5000 ticks.
        tick_1khz = 1'b1;
        step(5000);
        tick_1khz = 1'b0; wire_cut = CUT_DEFUSE;
        push_exp("pre_def_state", ST_ARMED);
        step(1);
        observe(state);
        push_exp("def_state", ST_DEFUSED);
        push_exp("def_pulse", 1);
        push_exp("def_elapsed", 5000);
        push_exp("def_flash", 1);
        step(1);
        observe(state); observe(defuse_pulse); observe(elapsed_ms); observe(flash);
        push_exp("def_pulse_gone", 0);
        step(1);
        observe(defuse_pulse);

        // Terminal state ignores further events.
        times_up = 1'b1; wire_cut = CUT_WRONG;
        push_exp("latch_state", ST_DEFUSED);
        push_exp("latch_elapsed", 5000);
        step(4);
        observe(state); observe(elapsed_ms);
        push_exp("latch_def_count", 1);
        push_exp("latch_exp_count", 0);
        observe(n_def); observe(n_exp);

        // Disarm: one edge of input latency, then HOME.
        arm = 1'b0; times_up = 1'b0; wire_cut = 3'b000;
        push_exp("home_lag_state", ST_DEFUSED);
        step(1);
        observe(state);
        push_exp("home_state", ST_HOME);
        push_exp("home_game_reset", 1);
        push_exp("home_elapsed", 0);
        push_exp("home_flash", 0);
        step(1);
        observe(state); observe(game_reset); observe(elapsed_ms); observe(flash);

        arm = 1'b1;
        push_exp("rearm_state", ST_ARMED);
        push_exp("rearm_elapsed", 0);
        push_exp("rearm_game_reset", 0);
        step(2);
        observe(state); observe(elapsed_ms); observe(game_reset);

        // Defuse and timeout in the same cycle: defuse wins.
        wire_cut = CUT_DEFUSE; times_up = 1'b1;
        push_exp("sim_state", ST_DEFUSED);
        push_exp("sim_defuse_pulse", 1);
        push_exp("sim_explode_pulse", 0);
        step(2);
        observe(state); observe(defuse_pulse); observe(explode_pulse);
        step(1);
        push_exp("sim_def_count", 2);
        push_exp("sim_exp_count", 0);
        observe(n_def); observe(n_exp);

        arm = 1'b0; wire_cut = 3'b000; times_up = 1'b0;
        push_exp("sim_home_state", ST_HOME);
        step(2);
        observe(state);

        // Arming is blocked while times_up is high.
        arm = 1'b1; times_up = 1'b1;
        push_exp("blocked_state", ST_HOME);
        step(3);
        observe(state);
        times_up = 1'b0;
        push_exp("unblocked_state", ST_ARMED);
        step(2);
        observe(state);

        // Wrong wire after 100 ticks, then the full explode flash sequence.
        tick_1khz = 1'b1;
        step(100);
        wire_cut = CUT_WRONG;
        push_exp("pre_exp_state", ST_ARMED);
        step(1);
        observe(state);
        push_exp("exp_state", ST_EXPLODED);
        push_exp("exp_pulse", 1);
        push_exp("exp_elapsed", 100);
        step(1);
        observe(state); observe(explode_pulse); observe(elapsed_ms);
        for (int k = 0; k < 2600; k++) begin
            if (k > 0) step(1);
            hp = (k + 1) / BLINK_MS;
            push_exp($sformatf("flash_k%0d", k), (hp >= FLASH_CYCLES) ? 0 : ((hp % 2) == 0));
            observe(flash);
        end
        push_exp("exp_hold_state", ST_EXPLODED);
        push_exp("exp_frozen_elapsed", 100);
        push_exp("exp_count", 1);
        observe(state); observe(elapsed_ms); observe(n_exp);

        arm = 1'b0; wire_cut = 3'b000; tick_1khz = 1'b0;
        push_exp("exp_home_state", ST_HOME);
        push_exp("exp_home_flash", 0);
        step(2);
        observe(state); observe(flash);

        // Reset 600 ticks into a flash sequence.
        arm = 1'b1;
        push_exp("re2_state", ST_ARMED);
        step(2);
        observe(state);
        tick_1khz = 1'b1; wire_cut = CUT_WRONG;
        push_exp("re2_exp_state", ST_EXPLODED);
        step(2);
        observe(state);
        step(600);
        push_exp("mid_flash", 1);
        observe(flash);
        reset = 1'b1;
        push_exp("midrst_state", ST_HOME);
        push_exp("midrst_flash", 0);
        push_exp("midrst_game_reset", 1);
        push_exp("midrst_elapsed", 0);
        push_exp("midrst_pulses", 0);
        step(1);
        observe(state); observe(flash); observe(game_reset); observe(elapsed_ms);
        observe({defuse_pulse, explode_pulse});

        // Saturation of elapsed_ms over 70000 ticks.
        reset = 1'b0; tick_1khz = 1'b0; wire_cut = 3'b000;
        push_exp("sat_arm_state", ST_ARMED);
        step(2);
        observe(state);
        tick_1khz = 1'b1;
        push_exp("sat_pre", 16'hFFFE);
        step(65535);
        observe(elapsed_ms);
        push_exp("sat_hit", 16'hFFFF);
        step(1);
        observe(elapsed_ms);
        push_exp("sat_hold", 16'hFFFF);
        push_exp("sat_state", ST_ARMED);
        step(4464);
        observe(elapsed_ms); observe(state);
        push_exp("total_def_count", 2);
        push_exp("total_exp_count", 2);
        observe(n_def); observe(n_exp);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
